// File: rtl/pfvf_rtable_lookup.sv
// PF/VF routing-table lookup: 2-stage match + priority encode, one lookup per cycle, whole pipe stalls on rsp backpressure.
// Optional miss statistics are enabled by defining PFVF_RTABLE_MISS_STAT_EN.
module pfvf_rtable_lookup #(
    parameter int NUM_ENTRIES = 8,
    parameter int NUM_PORT    = 4,
    parameter int TAG_WIDTH   = 8,
    parameter int DEFAULT_PID = NUM_PORT - 1,
    localparam int NID_WIDTH  = ($clog2(NUM_PORT) > 1) ? $clog2(NUM_PORT) : 1,
    localparam int IDX_W      = ($clog2(NUM_ENTRIES) > 1) ? $clog2(NUM_ENTRIES) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_wr_en,
    input  logic [IDX_W-1:0]     cfg_wr_idx,
    input  logic                 cfg_wr_vld,
    input  logic                 cfg_wr_pf_wild,
    input  logic                 cfg_wr_vf_wild,
    input  logic [2:0]           cfg_wr_pf,
    input  logic [10:0]          cfg_wr_vf,
    input  logic                 cfg_wr_va,
    input  logic [NID_WIDTH-1:0] cfg_wr_pid,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [2:0]           req_pf,
    input  logic [10:0]          req_vf,
    input  logic                 req_va,
    input  logic [TAG_WIDTH-1:0] req_tag,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [NID_WIDTH-1:0] rsp_pid,
    output logic                 rsp_hit,
    output logic [IDX_W-1:0]     rsp_idx,
    output logic [TAG_WIDTH-1:0] rsp_tag,
    output logic [31:0]          miss_cnt,
    output logic                 miss_sticky,
    input  logic                 miss_clr
);

    logic [NUM_ENTRIES-1:0] r_vld, r_pf_wild, r_vf_wild, r_va;
    logic [2:0]             r_pf  [NUM_ENTRIES];
    logic [10:0]            r_vf  [NUM_ENTRIES];
    logic [NID_WIDTH-1:0]   r_pid [NUM_ENTRIES];

    logic                   r_s1_vld;
    logic [NUM_ENTRIES-1:0] r_s1_match;
    logic [NID_WIDTH-1:0]   r_s1_pid [NUM_ENTRIES];
    logic [TAG_WIDTH-1:0]   r_s1_tag;

    logic                   r_rsp_vld, r_rsp_hit;
    logic [NID_WIDTH-1:0]   r_rsp_pid;
    logic [IDX_W-1:0]       r_rsp_idx;
    logic [TAG_WIDTH-1:0]   r_rsp_tag;

    logic                   w_adv, w_wr_ok, w_enc_hit;
    logic [NUM_ENTRIES-1:0] w_match;
    logic [NID_WIDTH-1:0]   w_enc_pid;
    logic [IDX_W-1:0]       w_enc_idx;

    assign w_adv     = !(r_rsp_vld && !rsp_ready);
    assign req_ready = rst || w_adv;
    assign w_wr_ok   = cfg_wr_en && (int'(cfg_wr_idx) < NUM_ENTRIES);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld     <= '0;
            r_pf_wild <= '0;
            r_vf_wild <= '0;
            r_va      <= '0;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                r_pf[i]  <= '0;
                r_vf[i]  <= '0;
                r_pid[i] <= '0;
            end
        end else if (w_wr_ok) begin
            r_vld[cfg_wr_idx]     <= cfg_wr_vld;
            r_pf_wild[cfg_wr_idx] <= cfg_wr_pf_wild;
            r_vf_wild[cfg_wr_idx] <= cfg_wr_vf_wild;
            r_va[cfg_wr_idx]      <= cfg_wr_va;
            r_pf[cfg_wr_idx]      <= cfg_wr_pf;
            r_vf[cfg_wr_idx]      <= cfg_wr_vf;
            r_pid[cfg_wr_idx]     <= cfg_wr_pid;
        end
    end

    // PF requests (va=0) ignore the VF field entirely.
    always_comb begin
        w_match = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            w_match[i] = r_vld[i] && (r_va[i] == req_va)
                       && (r_pf_wild[i] || (r_pf[i] == req_pf))
                       && (r_vf_wild[i] || !req_va || (r_vf[i] == req_vf));
        end
    end

    // Pids are snapshotted with the match vector so a stalled request is immune to later writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_vld   <= 1'b0;
            r_s1_match <= '0;
            r_s1_tag   <= '0;
            for (int i = 0; i < NUM_ENTRIES; i++) r_s1_pid[i] <= '0;
        end else if (w_adv) begin
            r_s1_vld <= req_valid;
            if (req_valid) begin
                r_s1_match <= w_match;
                r_s1_tag   <= req_tag;
                for (int i = 0; i < NUM_ENTRIES; i++) r_s1_pid[i] <= r_pid[i];
            end
        end
    end

    always_comb begin
        w_enc_hit = 1'b0;
        w_enc_pid = NID_WIDTH'(DEFAULT_PID);
        w_enc_idx = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (r_s1_match[i]) begin
                w_enc_hit = 1'b1;
                w_enc_pid = r_s1_pid[i];
                w_enc_idx = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_vld <= 1'b0;
            r_rsp_hit <= 1'b0;
            r_rsp_pid <= '0;
            r_rsp_idx <= '0;
            r_rsp_tag <= '0;
        end else if (w_adv) begin
            r_rsp_vld <= r_s1_vld;
            if (r_s1_vld) begin
                r_rsp_hit <= w_enc_hit;
                r_rsp_pid <= w_enc_pid;
                r_rsp_idx <= w_enc_idx;
                r_rsp_tag <= r_s1_tag;
            end
        end
    end

    assign rsp_valid = r_rsp_vld;
    assign rsp_hit   = r_rsp_hit;
    assign rsp_pid   = r_rsp_pid;
    assign rsp_idx   = r_rsp_idx;
    assign rsp_tag   = r_rsp_tag;

`ifdef PFVF_RTABLE_MISS_STAT_EN
    logic [31:0] r_miss_cnt;
    logic        r_miss_sticky;

    always_ff @(posedge clk) begin
        if (rst || miss_clr) begin
            r_miss_cnt    <= '0;
            r_miss_sticky <= 1'b0;
        end else if (r_rsp_vld && rsp_ready && !r_rsp_hit) begin
            if (r_miss_cnt != 32'hFFFF_FFFF) r_miss_cnt <= r_miss_cnt + 32'd1;
            r_miss_sticky <= 1'b1;
        end
    end

    assign miss_cnt    = r_miss_cnt;
    assign miss_sticky = r_miss_sticky;
`else
    logic w_unused_miss_clr;
    assign w_unused_miss_clr = miss_clr;
    assign miss_cnt          = '0;
    assign miss_sticky       = 1'b0;
`endif

endmodule
